// File: rtl/stream_kernel_pooler.sv
`default_nettype none
// ============================================================================
// Module  : stream_kernel_pooler
// Brief   : Streaming KXxKY MAX/MIN pooler over a KY-row line buffer with
//           valid/ready handshakes on input pixels and pooled results.
// Revision: 1.0 - initial release
// ============================================================================
module stream_kernel_pooler #(
    parameter int DEPTH  = 8,
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int AX     = 8,
    parameter int AY     = 8,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DEPTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DEPTH-1:0] m_data,
    output logic             m_last,
    output logic             frame_done,
    output logic             busy
);
    localparam int XW = (AX > 1) ? $clog2(AX) : 1;
    localparam int YW = (AY > 1) ? $clog2(AY) : 1;
    localparam int RW = (KY > 1) ? $clog2(KY) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OX = (AX - KX) / STRIDE + 1;
    localparam int OY = (AY - KY) / STRIDE + 1;

    localparam logic [XW-1:0] c_x_max     = XW'(AX - 1);
    localparam logic [YW-1:0] c_y_max     = YW'(AY - 1);
    localparam logic [XW-1:0] c_x_win     = XW'(KX - 1);
    localparam logic [YW-1:0] c_y_win     = YW'(KY - 1);
    localparam logic [XW-1:0] c_x_lastwin = XW'((OX - 1) * STRIDE + KX - 1);
    localparam logic [YW-1:0] c_y_lastwin = YW'((OY - 1) * STRIDE + KY - 1);
    localparam logic [RW-1:0] c_row_max   = RW'(KY - 1);
    localparam logic [PW-1:0] c_ph_max    = PW'(STRIDE - 1);
    localparam logic [RW:0]   c_ky        = (RW + 1)'(KY);

    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [RW-1:0]    r_row;
    logic [PW-1:0]    r_xph;
    logic [PW-1:0]    r_yph;
    logic             r_m_valid;
    logic [DEPTH-1:0] r_m_data;
    logic             r_m_last;
    logic             r_frame_done;
    logic             r_busy;
    logic [DEPTH-1:0] r_lb [0:KY-1][0:AX-1];

    logic             w_acc;
    logic             w_xfer;
    logic             w_x_end;
    logic             w_y_end;
    logic             w_win;
    logic             w_last_win;
    logic [DEPTH-1:0] w_best;
    logic [DEPTH-1:0] w_pix;
    logic [RW:0]      w_rsum;
    logic [RW-1:0]    w_ridx;
    logic [XW-1:0]    w_cidx;

    assign s_ready    = rst_n && (!r_m_valid || m_ready);
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_last     = r_m_last;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

    assign w_acc      = s_valid && s_ready && !clear;
    assign w_xfer     = r_m_valid && m_ready;
    assign w_x_end    = (r_x == c_x_max);
    assign w_y_end    = (r_y == c_y_max);
    // Phase counters stay 0 until the window fits, so a zero phase marks a stride hit.
    assign w_win      = (r_x >= c_x_win) && (r_y >= c_y_win) && (r_xph == '0) && (r_yph == '0);
    assign w_last_win = w_win && (r_x == c_x_lastwin) && (r_y == c_y_lastwin);

    // Window row dy maps to buffer row (y-KY+1+dy) mod KY = (row+1+dy) mod KY;
    // the completing pixel is taken straight from s_data.
    always_comb begin
        w_best = s_data;
        w_pix  = '0;
        w_rsum = '0;
        w_ridx = '0;
        w_cidx = '0;
        for (int dy = 0; dy < KY; dy++) begin
            w_rsum = {1'b0, r_row} + (RW + 1)'(dy + 1);
            w_ridx = (w_rsum >= c_ky) ? RW'(w_rsum - c_ky) : RW'(w_rsum);
            for (int dx = 0; dx < KX; dx++) begin
                w_cidx = r_x - c_x_win + XW'(dx);
                if (dy == KY - 1 && dx == KX - 1)
                    w_pix = s_data;
                else
                    w_pix = r_lb[w_ridx][w_cidx];
                if (mode ? (w_pix < w_best) : (w_pix > w_best))
                    w_best = w_pix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc)
            r_lb[r_row][r_x] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_row        <= '0;
            r_xph        <= '0;
            r_yph        <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else if (clear) begin
            r_x          <= '0;
            r_y          <= '0;
            r_row        <= '0;
            r_xph        <= '0;
            r_yph        <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= w_acc && w_x_end && w_y_end;

            if (w_acc) begin
                if (w_x_end) begin
                    r_x   <= '0;
                    r_xph <= '0;
                    if (w_y_end) begin
                        r_y   <= '0;
                        r_row <= '0;
                        r_yph <= '0;
                    end else begin
                        r_y   <= r_y + YW'(1);
                        r_row <= (r_row == c_row_max) ? '0 : r_row + RW'(1);
                        if (r_y >= c_y_win)
                            r_yph <= (r_yph == c_ph_max) ? '0 : r_yph + PW'(1);
                    end
                end else begin
                    r_x <= r_x + XW'(1);
                    if (r_x >= c_x_win)
                        r_xph <= (r_xph == c_ph_max) ? '0 : r_xph + PW'(1);
                end
            end

            if (w_acc && w_win) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_best;
                r_m_last  <= w_last_win;
            end else if (w_xfer) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            // A final pixel that completes no window ends the frame on its own.
            if (w_acc && w_x_end && w_y_end && !w_win)
                r_busy <= 1'b0;
            else if (w_acc)
                r_busy <= 1'b1;
            else if (w_xfer && r_m_last)
                r_busy <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_kernel_pooler.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_kernel_pooler
// Brief   : Scoreboard bench for stream_kernel_pooler (STRIDE 1 and 2 DUTs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_kernel_pooler;
    localparam int AX   = 8;
    localparam int NPIX = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_valid2 = 1'b0;
    logic       m_ready = 1'b1;
    logic [7:0] s_data = 8'd0;

    logic       s_ready, m_valid, m_last, frame_done, busy;
    logic [7:0] m_data;
    logic       s_ready2, m_valid2, m_last2, frame_done2, busy2;
    logic [7:0] m_data2;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t       q1[$];
    exp_t       q2[$];
    int         total = 0;
    int         bad = 0;
    int         fd1 = 0;
    int         fd2 = 0;
    bit         rnd_ready = 1'b0;
    logic [7:0] fr [NPIX];

    stream_kernel_pooler #(.DEPTH(8), .KX(3), .KY(3), .AX(8), .AY(8), .STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frame_done(frame_done), .busy(busy)
    );

    stream_kernel_pooler #(.DEPTH(8), .KX(3), .KY(3), .AX(8), .AY(8), .STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2),
        .frame_done(frame_done2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: a transfer is committed when valid && ready hold at the negedge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (frame_done === 1'b1) fd1++;
        if (frame_done2 === 1'b1) fd2++;
        if (rst_n && m_valid && m_ready) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL s1_unexpected: got data=%0d last=%0d expected none", m_data, m_last);
            end else begin
                e = q1.pop_front();
                if (m_data !== e.d || m_last !== e.last) begin
                    bad++;
                    $display("FAIL s1_result: got data=%0d last=%0d expected data=%0d last=%0d",
                             m_data, m_last, e.d, e.last);
                end
            end
        end
        if (rst_n && m_valid2 && m_ready) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL s2_unexpected: got data=%0d last=%0d expected none", m_data2, m_last2);
            end else begin
                e = q2.pop_front();
                if (m_data2 !== e.d || m_last2 !== e.last) begin
                    bad++;
                    $display("FAIL s2_result: got data=%0d last=%0d expected data=%0d last=%0d",
                             m_data2, m_last2, e.d, e.last);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, input logic last, input bit to2);
        exp_t e;
        e.d    = d;
        e.last = last;
        if (to2) q2.push_back(e);
        else     q1.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_px(input logic [7:0] d, input bit to2);
        int n = 0;
        s_data = d;
        if (to2) s_valid2 = 1'b1;
        else     s_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (to2 ? s_ready2 : s_ready) break;
            n++;
            if (n > 300) begin
                check("send_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        s_valid2 = 1'b0;
    endtask

    task automatic stream_frame(input bit to2, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            send_px(fr[i], to2);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({name, "_pending"}, q1.size() + q2.size(), 0);
        check({name, "_mvalid_idle"}, {31'd0, m_valid | m_valid2}, 0);
    endtask

    task automatic ramp_fill();
        for (int i = 0; i < NPIX; i++) fr[i] = 8'(i);
    endtask

    // Ramp MAX golden: bottom-right pixel of each window.
    task automatic push_ramp_max();
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++)
                push(8'((oy + 2) * 8 + ox + 2), oy == 5 && ox == 5, 1'b0);
    endtask

    function automatic logic [7:0] pool(input int ox, input int oy, input bit mn);
        logic [7:0] b;
        logic [7:0] v;
        b = fr[oy * AX + ox];
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                v = fr[(oy + dy) * AX + ox + dx];
                if (mn ? (v < b) : (v > b)) b = v;
            end
        return b;
    endfunction

    task automatic push_model(input bit mn);
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++)
                push(pool(ox, oy, mn), oy == 5 && ox == 5, 1'b0);
    endtask

    task automatic push_partial(input int npx);
        for (int i = 0; i < npx; i++)
            if (i % 8 >= 2 && i / 8 >= 2) push(8'(i), 1'b0, 1'b0);
    endtask

    initial begin
        int fd_base;
        logic [7:0] s2_tab [9];
        s2_tab = '{8'd18, 8'd20, 8'd22, 8'd34, 8'd36, 8'd38, 8'd50, 8'd52, 8'd54};

        #1 rst_n = 1'b0;
        #11;
        check("rst_s_ready", {31'd0, s_ready}, 0);
        check("rst_m_valid", {31'd0, m_valid}, 0);
        check("rst_m_data", {24'd0, m_data}, 0);
        check("rst_m_last", {31'd0, m_last}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rel_s_ready", {31'd0, s_ready}, 1);
        @(posedge clk);
        #1;

        // Ramp, MAX, with first-result latency checks.
        ramp_fill();
        mode = 1'b0;
        push_ramp_max();
        fd_base = fd1;
        for (int i = 0; i < NPIX; i++) begin
            send_px(fr[i], 1'b0);
            if (i == 0)  check("busy_first_px", {31'd0, busy}, 1);
            if (i == 17) check("pre_first_valid", {31'd0, m_valid}, 0);
            if (i == 18) begin
                check("first_valid", {31'd0, m_valid}, 1);
                check("first_data", {24'd0, m_data}, 18);
            end
        end
        drain("ramp_max");
        check("ramp_max_frame_done", fd1 - fd_base, 1);
        check("ramp_max_busy_end", {31'd0, busy}, 0);

        // Ramp, MIN.
        mode = 1'b1;
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++)
                push(8'(oy * 8 + ox), oy == 5 && ox == 5, 1'b0);
        stream_frame(1'b0, 1'b0);
        drain("ramp_min");
        mode = 1'b0;

        // STRIDE=2 instance, ramp, MAX.
        for (int i = 0; i < 9; i++) push(s2_tab[i], i == 8, 1'b1);
        fd_base = fd2;
        stream_frame(1'b1, 1'b0);
        drain("stride2");
        check("stride2_frame_done", fd2 - fd_base, 1);
        check("stride2_busy_end", {31'd0, busy2}, 0);

        // Backpressure on the first result.
        push_ramp_max();
        fork
            stream_frame(1'b0, 1'b0);
            begin
                int n = 0;
                while (!m_valid && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid_held", {31'd0, m_valid}, 1);
                    check("bp_data_stable", {24'd0, m_data}, 18);
                    check("bp_s_ready_low", {31'd0, s_ready}, 0);
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Synchronous clear after 30 pixels; the 31st pixel is dropped.
        push_partial(30);
        for (int i = 0; i < 30; i++) send_px(fr[i], 1'b0);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'd30;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        check("clr_m_valid", {31'd0, m_valid}, 0);
        check("clr_m_last", {31'd0, m_last}, 0);
        check("clr_busy", {31'd0, busy}, 0);
        check("clr_s_ready", {31'd0, s_ready}, 1);
        push_ramp_max();
        fd_base = fd1;
        stream_frame(1'b0, 1'b0);
        drain("after_clear");
        check("after_clear_frame_done", fd1 - fd_base, 1);

        // Asynchronous reset pulse between edges; result of pixel 29 is lost.
        push_partial(29);
        for (int i = 0; i < 30; i++) send_px(fr[i], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 0);
        check("arst_m_data", {24'd0, m_data}, 0);
        check("arst_s_ready", {31'd0, s_ready}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_ramp_max();
        stream_frame(1'b0, 1'b0);
        drain("after_arst");

        // All-0xFF frames back to back, MAX then MIN.
        for (int i = 0; i < NPIX; i++) fr[i] = 8'hFF;
        for (int k = 0; k < 72; k++) push(8'hFF, (k % 36) == 35, 1'b0);
        fd_base = fd1;
        stream_frame(1'b0, 1'b0);
        mode = 1'b1;
        stream_frame(1'b0, 1'b0);
        drain("all_ff");
        check("all_ff_frame_done", fd1 - fd_base, 2);
        mode = 1'b0;

        // Random frames with random s_valid gaps and m_ready.
        rnd_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom);
            mode = 1'(m);
            push_model(1'(m));
            stream_frame(1'b0, 1'b1);
            drain(m == 0 ? "rand_max" : "rand_min");
        end
        rnd_ready = 1'b0;
        m_ready   = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
